// File: rtl/pipelined_block_ram_pkg.sv
// rtl/pipelined_block_ram_pkg.sv - request decode helpers local to the pipelined block RAM
package pipelined_block_ram_pkg;
  import tilelink_pkg::*;

  localparam int BYTE_LANES = 4;

  typedef enum logic [1:0] {
    REQ_GET,
    REQ_PUT_FULL,
    REQ_PUT_PARTIAL,
    REQ_BAD
  } req_kind_e;

  function automatic req_kind_e decode_kind(input logic [2:0] opcode);
    case (opcode)
      TL_GET:              return REQ_GET;
      TL_PUT_FULL_DATA:    return REQ_PUT_FULL;
      TL_PUT_PARTIAL_DATA: return REQ_PUT_PARTIAL;
      default:             return REQ_BAD;
    endcase
  endfunction

endpackage

// File: rtl/tilelink_pkg.sv
// rtl/tilelink_pkg.sv - shared TileLink-UL opcode constants and A/D channel structs
package tilelink_pkg;

  localparam logic [2:0] TL_GET              = 3'd4;
  localparam logic [2:0] TL_PUT_FULL_DATA    = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL_DATA = 3'd1;
  localparam logic [2:0] TL_ACCESS_ACK       = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK_DATA  = 3'd1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [2:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
  } tilelink_a;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [2:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic        d_error;
    logic [31:0] d_data;
    logic        d_ready;
  } tilelink_d;

endpackage

// File: rtl/pipelined_block_ram_fifo.sv
// rtl/pipelined_block_ram_fifo.sv - bram_resp_fifo: fall-through response queue carrying tilelink_d
module bram_resp_fifo
  import tilelink_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clock,
  input  logic      reset_n,
  input  logic      in_valid,
  output logic      in_ready,
  input  tilelink_d in_data,
  output logic      out_valid,
  input  logic      out_ready,
  output tilelink_d out_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  tilelink_d       store [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            empty, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // An empty queue passes the incoming entry straight through so the
  // response is visible in the same cycle the pipeline produces it.
  always_comb begin
    empty     = (count_q == '0);
    in_ready  = (count_q != CW'(DEPTH));
    out_valid = !empty || in_valid;
    out_data  = empty ? in_data : store[rd_ptr_q];
    pop       = !empty && out_ready;
    push      = in_valid && in_ready && !(empty && out_ready);
    wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d   = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) store[wr_ptr_q] <= in_data;
  end

endmodule

// File: rtl/pipelined_block_ram.sv
// rtl/pipelined_block_ram.sv - TileLink-UL block RAM with 1/2-cycle read pipeline and response queue
// PIPELINED_BLOCK_RAM_RANGE_ERR_EN: flag selected offsets beyond DEPTH_WORDS instead of wrapping.
module pipelined_block_ram
  import tilelink_pkg::*;
  import pipelined_block_ram_pkg::*;
#(
  parameter logic [31:0] ADDR_MASK    = 32'hF000_0000,
  parameter logic [31:0] ADDR_TAG     = 32'h0000_0000,
  parameter int          DEPTH_WORDS  = 16384,
  parameter int          READ_LATENCY = 1,
  parameter string       FILENAME     = ""
) (
  input  logic      clock,
  input  logic      reset_n,
  input  tilelink_a tla,
  output logic      a_ready,
  output tilelink_d tld,
  input  logic      host_d_ready
);

  localparam int         IW           = $clog2(DEPTH_WORDS);
  localparam int         FIFO_DEPTH   = READ_LATENCY + 1;
  localparam logic [2:0] MAX_INFLIGHT = 3'(READ_LATENCY + 1);

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   rdata_q;
  logic          selected, accept, consume, range_err, wr_en;
  logic [IW-1:0] idx;
  logic [3:0]    wr_be;
  req_kind_e     kind;

  logic          ready_en_q, ready_en_d;
  logic [2:0]    inflight_q, inflight_d;
  logic          s1_valid_q, s1_valid_d, s1_error_q, s1_error_d, s1_zero_q, s1_zero_d;
  logic [2:0]    s1_opcode_q, s1_opcode_d, s1_size_q, s1_size_d;
  logic [7:0]    s1_source_q, s1_source_d;

  tilelink_d     s1_resp, pipe_resp, fifo_out;
  logic          fifo_in_ready, fifo_out_valid;
  logic          unused_bits;

  always_comb begin
    selected    = ((tla.a_address & ADDR_MASK) == ADDR_TAG);
    consume     = fifo_out_valid && host_d_ready;
    a_ready     = ready_en_q && ((inflight_q < MAX_INFLIGHT) || consume);
    accept      = tla.a_valid && selected && a_ready;
    idx         = tla.a_address[IW+1:2];
    kind        = decode_kind(tla.a_opcode);
`ifdef PIPELINED_BLOCK_RAM_RANGE_ERR_EN
    range_err   = |((tla.a_address & ~ADDR_MASK) >> (IW + 2));
`else
    range_err   = 1'b0;
`endif
    wr_be       = (kind == REQ_PUT_FULL) ? 4'hF : tla.a_mask;
    wr_en       = accept && !range_err && ((kind == REQ_PUT_FULL) || (kind == REQ_PUT_PARTIAL));
    ready_en_d  = 1'b1;
    inflight_d  = inflight_q + {2'b00, accept} - {2'b00, consume};
    s1_valid_d  = accept;
    s1_opcode_d = (kind == REQ_GET) ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
    s1_size_d   = tla.a_size;
    s1_source_d = tla.a_source;
    s1_error_d  = range_err || (kind == REQ_BAD);
    s1_zero_d   = range_err;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ready_en_q  <= 1'b0;
      inflight_q  <= '0;
      s1_valid_q  <= 1'b0;
      s1_opcode_q <= '0;
      s1_size_q   <= '0;
      s1_source_q <= '0;
      s1_error_q  <= 1'b0;
      s1_zero_q   <= 1'b0;
    end else begin
      ready_en_q  <= ready_en_d;
      inflight_q  <= inflight_d;
      s1_valid_q  <= s1_valid_d;
      s1_opcode_q <= s1_opcode_d;
      s1_size_q   <= s1_size_d;
      s1_source_q <= s1_source_d;
      s1_error_q  <= s1_error_d;
      s1_zero_q   <= s1_zero_d;
    end
  end

  // Write-first port: written lanes return the new bytes, so a Put's
  // response carries the merged word without a second read.
  always_ff @(posedge clock) begin
    for (int b = 0; b < BYTE_LANES; b++) begin
      if (wr_en && wr_be[b]) begin
        mem[idx][8*b +: 8] <= tla.a_data[8*b +: 8];
        rdata_q[8*b +: 8]  <= tla.a_data[8*b +: 8];
      end else begin
        rdata_q[8*b +: 8]  <= mem[idx][8*b +: 8];
      end
    end
  end

  always_comb begin
    s1_resp          = '0;
    s1_resp.d_valid  = s1_valid_q;
    s1_resp.d_opcode = s1_opcode_q;
    s1_resp.d_size   = s1_size_q;
    s1_resp.d_source = s1_source_q;
    s1_resp.d_error  = s1_error_q;
    s1_resp.d_data   = s1_zero_q ? 32'h0 : rdata_q;
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      tilelink_d s2_resp_q, s2_resp_d;
      always_comb s2_resp_d = s1_resp;
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) s2_resp_q <= '0;
        else          s2_resp_q <= s2_resp_d;
      end
      assign pipe_resp = s2_resp_q;
    end else begin : g_lat1
      assign pipe_resp = s1_resp;
    end
  endgenerate

  bram_resp_fifo #(
    .DEPTH     (FIFO_DEPTH)
  ) u_resp_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (pipe_resp.d_valid),
    .in_ready  (fifo_in_ready),
    .in_data   (pipe_resp),
    .out_valid (fifo_out_valid),
    .out_ready (host_d_ready),
    .out_data  (fifo_out)
  );

  always_comb begin
    tld = '0;
    if (fifo_out_valid) tld = fifo_out;
    tld.d_valid = fifo_out_valid;
    tld.d_ready = a_ready;
  end

  assign unused_bits = ^{tla, fifo_out.d_ready, fifo_in_ready};

endmodule

// File: tb/tb_pipelined_block_ram.sv
// tb/tb_pipelined_block_ram.sv - directed self-checking bench: latency 1 (256 words) and latency 2 instances
module tb_pipelined_block_ram;
  import tilelink_pkg::*;

  logic      clock = 1'b0;
  logic      reset_n;
  tilelink_a tla1, tla2;
  tilelink_d tld1, tld2;
  logic      a_ready1, a_ready2, host1, host2;
  int        cmp = 0;
  int        errs = 0;

  always #5 clock = ~clock;

  pipelined_block_ram #(.DEPTH_WORDS(256), .READ_LATENCY(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .tla(tla1), .a_ready(a_ready1), .tld(tld1), .host_d_ready(host1));

  pipelined_block_ram #(.READ_LATENCY(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .tla(tla2), .a_ready(a_ready2), .tld(tld2), .host_d_ready(host2));

  task automatic set_a1(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] data, input logic [7:0] src);
    tla1 = '0;
    tla1.a_valid = 1'b1; tla1.a_opcode = op; tla1.a_size = 3'd2; tla1.a_source = src;
    tla1.a_address = addr; tla1.a_mask = mask; tla1.a_data = data;
  endtask

  task automatic set_a2(input logic [2:0] op, input logic [31:0] addr, input logic [7:0] src, input logic [31:0] data);
    tla2 = '0;
    tla2.a_valid = 1'b1; tla2.a_opcode = op; tla2.a_size = 3'd2; tla2.a_source = src;
    tla2.a_address = addr; tla2.a_mask = 4'hF; tla2.a_data = data;
  endtask

  // One request on dut1; returns in the cycle after the accepting edge.
  task automatic issue1(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] data, input logic [7:0] src);
    @(posedge clock); #1;
    set_a1(op, addr, mask, data, src);
    @(posedge clock); #1;
    tla1.a_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1; tla1 = '0; tla2 = '0; host1 = 1'b1; host2 = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    cmp++; if (a_ready1 !== 1'b0) begin errs++; $display("FAIL rst_a_ready1: got %b want 0", a_ready1); end
    cmp++; if (tld1.d_valid !== 1'b0 || tld1.d_error !== 1'b0) begin errs++; $display("FAIL rst_d1: got v%b e%b want v0 e0", tld1.d_valid, tld1.d_error); end
    cmp++; if (a_ready2 !== 1'b0 || tld2.d_valid !== 1'b0) begin errs++; $display("FAIL rst_dut2: got r%b v%b want r0 v0", a_ready2, tld2.d_valid); end
    @(posedge clock); #1;
    cmp++; if (a_ready1 !== 1'b0) begin errs++; $display("FAIL rst_edge_a_ready1: got %b want 0", a_ready1); end
    reset_n = 1'b1;
    @(posedge clock); #1;
    cmp++; if (a_ready1 !== 1'b1 || a_ready2 !== 1'b1) begin errs++; $display("FAIL rst_release_ready: got %b%b want 11", a_ready1, a_ready2); end
    cmp++; if (tld1.d_valid !== 1'b0 || tld2.d_valid !== 1'b0) begin errs++; $display("FAIL rst_release_dvalid: got %b%b want 00", tld1.d_valid, tld2.d_valid); end
  endtask

  task automatic test_back_to_back();
    host1 = 1'b1;
    @(posedge clock); #1;
    set_a1(TL_PUT_FULL_DATA, 32'h100, 4'hF, 32'hDEADBEEF, 8'd1);
    #1;
    cmp++; if (a_ready1 !== 1'b1) begin errs++; $display("FAIL b2b_ready0: got %b want 1", a_ready1); end
    @(posedge clock); #1;
    set_a1(TL_GET, 32'h100, 4'hF, 32'h0, 8'd2);
    #1;
    cmp++; if (tld1.d_valid !== 1'b1 || tld1.d_opcode !== TL_ACCESS_ACK || tld1.d_data !== 32'hDEADBEEF || tld1.d_source !== 8'd1 || tld1.d_error !== 1'b0)
      begin errs++; $display("FAIL b2b_put_resp: got v%b op%0d d%h s%0d e%b want v1 op0 dDEADBEEF s1 e0", tld1.d_valid, tld1.d_opcode, tld1.d_data, tld1.d_source, tld1.d_error); end
    cmp++; if (a_ready1 !== 1'b1) begin errs++; $display("FAIL b2b_ready1: got %b want 1", a_ready1); end
    cmp++; if (tld1.d_size !== 3'd2 || tld1.d_param !== 2'd0 || tld1.d_sink !== 1'b0) begin errs++; $display("FAIL b2b_fields: got sz%0d p%0d k%b want sz2 p0 k0", tld1.d_size, tld1.d_param, tld1.d_sink); end
    @(posedge clock); #1;
    tla1.a_valid = 1'b0;
    #1;
    cmp++; if (tld1.d_valid !== 1'b1 || tld1.d_opcode !== TL_ACCESS_ACK_DATA || tld1.d_data !== 32'hDEADBEEF || tld1.d_source !== 8'd2)
      begin errs++; $display("FAIL b2b_get_resp: got v%b op%0d d%h s%0d want v1 op1 dDEADBEEF s2", tld1.d_valid, tld1.d_opcode, tld1.d_data, tld1.d_source); end
    @(posedge clock); #2;
    cmp++; if (tld1.d_valid !== 1'b0) begin errs++; $display("FAIL b2b_idle: got %b want 0", tld1.d_valid); end
  endtask

  task automatic test_partial();
    issue1(TL_PUT_FULL_DATA, 32'h104, 4'hF, 32'h11223344, 8'd3);
    cmp++; if (tld1.d_valid !== 1'b1 || tld1.d_data !== 32'h11223344) begin errs++; $display("FAIL part_seed: got v%b d%h want v1 d11223344", tld1.d_valid, tld1.d_data); end
    issue1(TL_PUT_PARTIAL_DATA, 32'h104, 4'b0101, 32'hAABBCCDD, 8'd4);
    cmp++; if (tld1.d_opcode !== TL_ACCESS_ACK || tld1.d_data !== 32'h11BB33DD) begin errs++; $display("FAIL part_resp: got op%0d d%h want op0 d11BB33DD", tld1.d_opcode, tld1.d_data); end
    issue1(TL_GET, 32'h107, 4'hF, 32'h0, 8'd5);
    cmp++; if (tld1.d_opcode !== TL_ACCESS_ACK_DATA || tld1.d_data !== 32'h11BB33DD) begin errs++; $display("FAIL part_get: got op%0d d%h want op1 d11BB33DD", tld1.d_opcode, tld1.d_data); end
  endtask

  task automatic test_unselected();
    @(posedge clock); #1;
    set_a1(TL_PUT_FULL_DATA, 32'h1000_0100, 4'hF, 32'h0, 8'd6);
    #1;
    cmp++; if (a_ready1 !== 1'b1 || tld1.d_valid !== 1'b0) begin errs++; $display("FAIL unsel_drive: got r%b v%b want r1 v0", a_ready1, tld1.d_valid); end
    @(posedge clock); #1;
    tla1.a_valid = 1'b0;
    #1;
    cmp++; if (tld1.d_valid !== 1'b0) begin errs++; $display("FAIL unsel_noresp: got %b want 0", tld1.d_valid); end
    issue1(TL_GET, 32'h100, 4'hF, 32'h0, 8'd7);
    cmp++; if (tld1.d_data !== 32'hDEADBEEF) begin errs++; $display("FAIL unsel_nowrite: got %h want DEADBEEF", tld1.d_data); end
  endtask

  task automatic test_opcode_and_range();
    issue1(3'd2, 32'h100, 4'hF, 32'h0, 8'd8);
    cmp++; if (tld1.d_opcode !== TL_ACCESS_ACK || tld1.d_error !== 1'b1) begin errs++; $display("FAIL badop_resp: got op%0d e%b want op0 e1", tld1.d_opcode, tld1.d_error); end
    issue1(TL_GET, 32'h100, 4'hF, 32'h0, 8'd9);
    cmp++; if (tld1.d_data !== 32'hDEADBEEF || tld1.d_error !== 1'b0) begin errs++; $display("FAIL badop_nowrite: got d%h e%b want dDEADBEEF e0", tld1.d_data, tld1.d_error); end
    issue1(TL_PUT_FULL_DATA, 32'h3FC, 4'hF, 32'h0BADF00D, 8'd10);
    issue1(TL_GET, 32'h3FC, 4'hF, 32'h0, 8'd11);
    cmp++; if (tld1.d_data !== 32'h0BADF00D || tld1.d_error !== 1'b0) begin errs++; $display("FAIL last_word: got d%h e%b want d0BADF00D e0", tld1.d_data, tld1.d_error); end
    issue1(TL_PUT_FULL_DATA, 32'h0, 4'hF, 32'hCAFEF00D, 8'd12);
    issue1(TL_GET, 32'h400, 4'hF, 32'h0, 8'd13);
`ifdef PIPELINED_BLOCK_RAM_RANGE_ERR_EN
    cmp++; if (tld1.d_error !== 1'b1 || tld1.d_data !== 32'h0) begin errs++; $display("FAIL range_get: got e%b d%h want e1 d0", tld1.d_error, tld1.d_data); end
`else
    cmp++; if (tld1.d_error !== 1'b0 || tld1.d_data !== 32'hCAFEF00D) begin errs++; $display("FAIL wrap_get: got e%b d%h want e0 dCAFEF00D", tld1.d_error, tld1.d_data); end
`endif
    issue1(TL_PUT_FULL_DATA, 32'h400, 4'hF, 32'h12345678, 8'd14);
    issue1(TL_GET, 32'h0, 4'hF, 32'h0, 8'd15);
`ifdef PIPELINED_BLOCK_RAM_RANGE_ERR_EN
    cmp++; if (tld1.d_data !== 32'hCAFEF00D) begin errs++; $display("FAIL range_nowrite: got %h want CAFEF00D", tld1.d_data); end
`else
    cmp++; if (tld1.d_data !== 32'h12345678) begin errs++; $display("FAIL wrap_write: got %h want 12345678", tld1.d_data); end
`endif
  endtask

  task automatic test_latency2();
    logic exp_v;
    host2 = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(posedge clock); #1;
      if (c < 3) set_a2(TL_PUT_FULL_DATA, 32'(32'h200 + 4 * c), 8'(c), 32'(32'hA0 + c));
      else tla2.a_valid = 1'b0;
      #1;
      exp_v = (c >= 2) && (c <= 4);
      cmp++; if (tld2.d_valid !== exp_v) begin errs++; $display("FAIL lat2_valid c%0d: got %b want %b", c, tld2.d_valid, exp_v); end
      if (exp_v) begin
        cmp++; if (tld2.d_data !== 32'(32'hA0 + c - 2) || tld2.d_source !== 8'(c - 2) || tld2.d_opcode !== TL_ACCESS_ACK)
          begin errs++; $display("FAIL lat2_resp c%0d: got d%h s%0d op%0d want d%h s%0d op0", c, tld2.d_data, tld2.d_source, tld2.d_opcode, 32'hA0 + c - 2, c - 2); end
      end
      cmp++; if (a_ready2 !== 1'b1) begin errs++; $display("FAIL lat2_ready c%0d: got %b want 1", c, a_ready2); end
    end
  endtask

  task automatic test_backpressure();
    logic exp_r, exp_v;
    int   k;
    int   acc = 0;
    host2 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clock); #1;
      if (c < 6) set_a2(TL_GET, 32'(32'h200 + 4 * (c % 3)), 8'(8 + c), 32'h0);
      else tla2.a_valid = 1'b0;
      if (c == 6) host2 = 1'b1;
      #1;
      exp_r = (c < 3) || (c >= 6);
      exp_v = (c >= 2) && (c <= 8);
      k = (c <= 6) ? 0 : c - 6;
      cmp++; if (a_ready2 !== exp_r) begin errs++; $display("FAIL bp_ready c%0d: got %b want %b", c, a_ready2, exp_r); end
      cmp++; if (tld2.d_valid !== exp_v) begin errs++; $display("FAIL bp_valid c%0d: got %b want %b", c, tld2.d_valid, exp_v); end
      if (exp_v) begin
        cmp++; if (tld2.d_data !== 32'(32'hA0 + k) || tld2.d_source !== 8'(8 + k) || tld2.d_opcode !== TL_ACCESS_ACK_DATA)
          begin errs++; $display("FAIL bp_resp c%0d: got d%h s%0d op%0d want d%h s%0d op1", c, tld2.d_data, tld2.d_source, tld2.d_opcode, 32'hA0 + k, 8 + k); end
      end
      if (tla2.a_valid && a_ready2) acc++;
    end
    cmp++; if (acc !== 3) begin errs++; $display("FAIL bp_accepted: got %0d want 3", acc); end
  endtask

  task automatic test_reset_mid();
    host2 = 1'b0;
    @(posedge clock); #1;
    set_a2(TL_GET, 32'h200, 8'd20, 32'h0);
    @(posedge clock); #1;
    set_a2(TL_GET, 32'h204, 8'd21, 32'h0);
    @(posedge clock); #1;
    tla2.a_valid = 1'b0;
    #1;
    cmp++; if (tld2.d_valid !== 1'b1 || tld2.d_data !== 32'hA0) begin errs++; $display("FAIL rmid_queued: got v%b d%h want v1 dA0", tld2.d_valid, tld2.d_data); end
    reset_n = 1'b0;
    #1;
    cmp++; if (tld2.d_valid !== 1'b0 || tld2.d_error !== 1'b0 || a_ready2 !== 1'b0) begin errs++; $display("FAIL rmid_assert: got v%b e%b r%b want v0 e0 r0", tld2.d_valid, tld2.d_error, a_ready2); end
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    cmp++; if (a_ready2 !== 1'b1 || a_ready1 !== 1'b1) begin errs++; $display("FAIL rmid_ready: got %b%b want 11", a_ready1, a_ready2); end
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      cmp++; if (tld2.d_valid !== 1'b0) begin errs++; $display("FAIL rmid_discard c%0d: got %b want 0", c, tld2.d_valid); end
    end
    host2 = 1'b1;
    set_a2(TL_GET, 32'h204, 8'd22, 32'h0);
    @(posedge clock); #1;
    tla2.a_valid = 1'b0;
    @(posedge clock); #1;
    cmp++; if (tld2.d_valid !== 1'b1 || tld2.d_data !== 32'hA1 || tld2.d_source !== 8'd22) begin errs++; $display("FAIL rmid_retain2: got v%b d%h s%0d want v1 dA1 s22", tld2.d_valid, tld2.d_data, tld2.d_source); end
    issue1(TL_GET, 32'h104, 4'hF, 32'h0, 8'd23);
    cmp++; if (tld1.d_data !== 32'h11BB33DD) begin errs++; $display("FAIL rmid_retain1: got %h want 11BB33DD", tld1.d_data); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_partial();
    test_unselected();
    test_opcode_and_range();
    test_latency2();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
